q_table_argmax: RTL and testbench

- Parametrised successor Q-table for the DynaQ agent.
- Holds NUM_STATES x NUM_ACTIONS signed Q-values in registers.
- Provides a registered full-row read port and a sequential max/argmax scan engine with a req/valid handshake.
- Sits between the reward/update datapath (write side) and the action-selection policy (row read and best action).

---
 rtl/q_table_argmax_if.sv | 31 +++
 rtl/q_table_argmax.sv | 157 +++++++++++++++
 tb/tb_q_table_argmax.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_table_argmax_if.sv
// Bus bundle for q_table_argmax: write port, row read port and max/argmax scan handshake.
// The policy/update side uses the master modport; the Q-table is the slave.
interface q_table_argmax_if #(
    parameter int DATA_LENGTH   = 32,
    parameter int NUM_ACTIONS   = 4,
    parameter int ACCESS_LENGTH = 8,
    parameter int ACTION_LENGTH = 2
);
    logic                                w_en;
    logic [ACCESS_LENGTH-1:0]            w_address;
    logic [ACTION_LENGTH-1:0]            action;
    logic [DATA_LENGTH-1:0]              w_data;
    logic                                w_err;
    logic [ACCESS_LENGTH-1:0]            r_address;
    logic [DATA_LENGTH*NUM_ACTIONS-1:0]  r_data;
    logic                                max_req;
    logic                                max_busy;
    logic                                max_valid;
    logic [DATA_LENGTH-1:0]              max_value;
    logic [ACTION_LENGTH-1:0]            max_action;

    modport master (
        output w_en, w_address, action, w_data, r_address, max_req,
        input  w_err, r_data, max_busy, max_valid, max_value, max_action
    );

    modport slave (
        input  w_en, w_address, action, w_data, r_address, max_req,
        output w_err, r_data, max_busy, max_valid, max_value, max_action
    );
endinterface

// File: rtl/q_table_argmax.sv
// Register-based DynaQ Q-table with a registered row read port and a sequential argmax scanner.
// Define Q_TABLE_SAT_ACC_EN to make valid writes saturating accumulates instead of overwrites.
module q_table_argmax #(
    parameter int DATA_LENGTH   = 32,
    parameter int NUM_STATES    = 25,
    parameter int NUM_ACTIONS   = 4,
    parameter int ACCESS_LENGTH = 8,
    parameter int ACTION_LENGTH = 2
) (
    input logic            clk,
    input logic            reset,
    q_table_argmax_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for max_req, entry 0 of the requested row latched on accept
    // SCAN  | comparing one action per cycle against the running best
    // DONE  | result registered, max_valid high for this single cycle
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic signed [DATA_LENGTH-1:0]       r_table [NUM_STATES][NUM_ACTIONS];
    logic [DATA_LENGTH*NUM_ACTIONS-1:0]  r_rd_row;
    logic                                r_err;
    state_t                              r_state;
    logic [ACCESS_LENGTH-1:0]            r_scan_s;
    logic [ACTION_LENGTH-1:0]            r_idx;
    logic signed [DATA_LENGTH-1:0]       r_best;
    logic [ACTION_LENGTH-1:0]            r_best_a;
    logic                                r_busy;
    logic                                r_valid;
    logic [DATA_LENGTH-1:0]              r_value;
    logic [ACTION_LENGTH-1:0]            r_action;

    logic [DATA_LENGTH*NUM_ACTIONS-1:0]  w_rd_row;
    logic signed [DATA_LENGTH-1:0]       w_scan_entry;
    logic                                w_wr_hit;
    logic                                w_gt;
    logic signed [DATA_LENGTH-1:0]       w_cand_best;
    logic [ACTION_LENGTH-1:0]            w_cand_a;

`ifdef Q_TABLE_SAT_ACC_EN
    function automatic logic signed [DATA_LENGTH-1:0] f_sat_add(
        input logic signed [DATA_LENGTH-1:0] old_v,
        input logic        [DATA_LENGTH-1:0] delta
    );
        logic [DATA_LENGTH:0] sum;
        sum = {old_v[DATA_LENGTH-1], old_v} + {delta[DATA_LENGTH-1], delta};
        if (sum[DATA_LENGTH] != sum[DATA_LENGTH-1])
            f_sat_add = sum[DATA_LENGTH] ? {1'b1, {(DATA_LENGTH-1){1'b0}}}
                                         : {1'b0, {(DATA_LENGTH-1){1'b1}}};
        else
            f_sat_add = sum[DATA_LENGTH-1:0];
    endfunction
`endif

    // Address decode by explicit match: unmatched addresses read as zero and flag writes as errors.
    always_comb begin
        w_rd_row     = '0;
        w_scan_entry = '0;
        w_wr_hit     = 1'b0;
        for (int s = 0; s < NUM_STATES; s++) begin
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                if (bus.r_address == ACCESS_LENGTH'(s))
                    w_rd_row[a*DATA_LENGTH +: DATA_LENGTH] = r_table[s][a];
                if (r_scan_s == ACCESS_LENGTH'(s) && r_idx == ACTION_LENGTH'(a))
                    w_scan_entry = r_table[s][a];
                if (bus.w_en && bus.w_address == ACCESS_LENGTH'(s) &&
                    bus.action == ACTION_LENGTH'(a))
                    w_wr_hit = 1'b1;
            end
        end
    end

    assign w_gt        = w_scan_entry > r_best;
    assign w_cand_best = w_gt ? w_scan_entry : r_best;
    assign w_cand_a    = w_gt ? r_idx : r_best_a;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STATES; s++)
                for (int a = 0; a < NUM_ACTIONS; a++)
                    r_table[s][a] <= '0;
            r_rd_row <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rd_row <= w_rd_row;
            r_err    <= bus.w_en && !w_wr_hit;
            for (int s = 0; s < NUM_STATES; s++) begin
                for (int a = 0; a < NUM_ACTIONS; a++) begin
                    if (bus.w_en && bus.w_address == ACCESS_LENGTH'(s) &&
                        bus.action == ACTION_LENGTH'(a)) begin
`ifdef Q_TABLE_SAT_ACC_EN
                        r_table[s][a] <= f_sat_add(r_table[s][a], bus.w_data);
`else
                        r_table[s][a] <= bus.w_data;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_scan_s <= '0;
            r_idx    <= '0;
            r_best   <= '0;
            r_best_a <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_value  <= '0;
            r_action <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.max_req) begin
                        r_scan_s <= bus.r_address;
                        r_best   <= w_rd_row[DATA_LENGTH-1:0];
                        r_best_a <= '0;
                        r_idx    <= ACTION_LENGTH'(1);
                        r_busy   <= 1'b1;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_best   <= w_cand_best;
                    r_best_a <= w_cand_a;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == ACTION_LENGTH'(NUM_ACTIONS-1)) begin
                        r_value  <= w_cand_best;
                        r_action <= w_cand_a;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.r_data     = r_rd_row;
    assign bus.w_err      = r_err;
    assign bus.max_busy   = r_busy;
    assign bus.max_valid  = r_valid;
    assign bus.max_value  = r_value;
    assign bus.max_action = r_action;
endmodule

// File: tb/tb_q_table_argmax.sv
// Self-checking bench for q_table_argmax: reference Q-table model plus a scoreboard of scan results.
module tb_q_table_argmax;
    localparam int DL  = 32;
    localparam int NS  = 25;
    localparam int NA  = 4;
    localparam int AL  = 8;
    localparam int ACL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    q_table_argmax_if #(.DATA_LENGTH(DL), .NUM_ACTIONS(NA), .ACCESS_LENGTH(AL),
                        .ACTION_LENGTH(ACL)) bus ();

    q_table_argmax #(.DATA_LENGTH(DL), .NUM_STATES(NS), .NUM_ACTIONS(NA),
                     .ACCESS_LENGTH(AL), .ACTION_LENGTH(ACL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    logic [DL-1:0]     m_tab [NS][NA];
    logic [DL+ACL-1:0] sb_q [$];
    logic [DL+ACL-1:0] sb_exp;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

`ifdef Q_TABLE_SAT_ACC_EN
    function automatic logic [DL-1:0] model_sat(input logic [DL-1:0] old_v, input logic [DL-1:0] d);
        longint s;
        s = longint'($signed(old_v)) + longint'($signed(d));
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[DL-1:0];
    endfunction
`endif

    function automatic void model_write(input int row, input int act, input logic [DL-1:0] d);
        if (row < NS && act < NA) begin
`ifdef Q_TABLE_SAT_ACC_EN
            m_tab[row][act] = model_sat(m_tab[row][act], d);
`else
            m_tab[row][act] = d;
`endif
        end
    endfunction

    function automatic logic [127:0] exp_row(input int row);
        if (row >= NS) return '0;
        return {m_tab[row][3], m_tab[row][2], m_tab[row][1], m_tab[row][0]};
    endfunction

    function automatic logic [DL+ACL-1:0] exp_max(input int row);
        logic signed [DL-1:0] best;
        int ba;
        if (row >= NS) return '0;
        best = m_tab[row][0];
        ba   = 0;
        for (int a = 1; a < NA; a++)
            if ($signed(m_tab[row][a]) > best) begin
                best = m_tab[row][a];
                ba   = a;
            end
        return {ACL'(ba), best};
    endfunction

    task automatic do_write(input int row, input int act, input logic [DL-1:0] d);
        bus.w_en      = 1'b1;
        bus.w_address = AL'(row);
        bus.action    = ACL'(act);
        bus.w_data    = d;
        tick;
        bus.w_en = 1'b0;
        model_write(row, act, d);
        check_val("w_err", bus.w_err, (row >= NS || act >= NA) ? 1 : 0);
    endtask

    task automatic do_read(input int row, input string tag);
        bus.r_address = AL'(row);
        tick;
        check_val(tag, bus.r_data, exp_row(row));
    endtask

    task automatic start_scan(input int row);
        bus.r_address = AL'(row);
        bus.max_req   = 1'b1;
        sb_q.push_back(exp_max(row));
        tick;
        bus.max_req = 1'b0;
    endtask

    // Counts cycles until max_valid is seen; an expired budget shows up as a latency mismatch.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (bus.max_valid) begin
                lat = k;
                break;
            end
        end
        check_val(tag, lat, exp_lat);
    endtask

    always @(negedge clk) begin
        if (reset && bus.max_valid) begin
            n_valid++;
            if (sb_q.size() == 0)
                check_val("sb_underflow", bus.max_valid, 0);
            else begin
                sb_exp = sb_q.pop_front();
                check_val("max_value", bus.max_value, sb_exp[DL-1:0]);
                check_val("max_action", bus.max_action, sb_exp[DL +: ACL]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        logic [127:0] old_row;

        reset = 1'b0;
        bus.w_en = 1'b0; bus.w_address = '0; bus.action = '0; bus.w_data = '0;
        bus.r_address = '0; bus.max_req = 1'b0;
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < NA; a++)
                m_tab[s][a] = '0;
        tick;
        tick;
        check_val("rst_r_data", bus.r_data, 0);
        check_val("rst_busy", bus.max_busy, 0);
        check_val("rst_valid", bus.max_valid, 0);
        check_val("rst_w_err", bus.w_err, 0);
        check_val("rst_value", bus.max_value, 0);
        reset = 1'b1;

        do_read(0, "rd_row0");
        do_read(24, "rd_row24");

        do_write(3, 0, 32'd5);
        do_write(3, 1, 32'hFFFF_FFFE);
        do_write(3, 2, 32'd9);
        do_write(3, 3, 32'd9);
        do_read(3, "rd_row3");
        check_val("row3_const", bus.r_data, {32'd9, 32'd9, 32'hFFFF_FFFE, 32'd5});
        start_scan(3);
        wait_valid("lat_row3", NA - 1);
        check_val("busy_done", bus.max_busy, 1);
        check_val("tie_value", bus.max_value, 32'd9);
        check_val("tie_action", bus.max_action, 2);
        tick;
        check_val("idle_busy", bus.max_busy, 0);
        check_val("valid_pulse", bus.max_valid, 0);
        check_val("hold_action", bus.max_action, 2);

        do_write(25, 0, 32'd123);
        tick;
        check_val("w_err_clear", bus.w_err, 0);
        do_write(255, 1, 32'd7);
        do_read(0, "oor_row0");
        do_read(3, "oor_row3");
        start_scan(30);
        wait_valid("lat_row30", NA - 1);
        tick;

        bus.r_address = AL'(7);
        old_row = exp_row(7);
        do_write(7, 1, 32'd100);
        check_val("rbw_old", bus.r_data, old_row);
        tick;
        check_val("rbw_new", bus.r_data, exp_row(7));

        do_write(11, 0, -32'sd5);
        do_write(11, 1, -32'sd3);
        do_write(11, 2, -32'sd3);
        do_write(11, 3, -32'sd7);
        n_before = n_valid;
        start_scan(11);
        bus.max_req = 1'b1;
        tick;
        tick;
        bus.max_req = 1'b0;
        wait_valid("lat_busy_req", 1);
        tick; tick; tick;
        check_val("busy_ignored", n_valid - n_before, 1);

        // Entries already compared must not see mid-scan writes; pending ones must.
        do_write(12, 0, 32'd1);
        do_write(12, 1, 32'd2);
        do_write(12, 2, 32'd3);
        do_write(12, 3, 32'd4);
        bus.r_address = AL'(12);
        bus.max_req = 1'b1;
        sb_q.push_back({2'd3, 32'd50});
        tick;
        bus.max_req = 1'b0;
        bus.w_en = 1'b1; bus.w_address = AL'(12); bus.action = 2'd3; bus.w_data = 32'd50;
        tick;
        model_write(12, 3, 32'd50);
        bus.action = 2'd0; bus.w_data = 32'd99;
        tick;
        model_write(12, 0, 32'd99);
        bus.w_en = 1'b0;
        wait_valid("lat_midwr", 1);
        tick;

        start_scan(3);
        wait_valid("lat_b2b_a", NA - 1);
        tick;
        start_scan(12);
        wait_valid("lat_b2b_b", NA - 1);
        tick;

        n_before = n_valid;
        start_scan(3);
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        void'(sb_q.pop_back());
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < NA; a++)
                m_tab[s][a] = '0;
        check_val("rst_mid_busy", bus.max_busy, 0);
        check_val("rst_mid_valid", bus.max_valid, 0);
        tick; tick; tick; tick; tick;
        check_val("rst_mid_no_valid", n_valid - n_before, 0);
        do_read(3, "rst_row3");
        do_read(12, "rst_row12");

        do_write(5, 0, 32'h7FFF_FFF0);
        do_write(5, 0, 32'h0000_0020);
        do_read(5, "acc_row5_a");
`ifdef Q_TABLE_SAT_ACC_EN
        check_val("sat_hi", bus.r_data[31:0], 32'h7FFF_FFFF);
`else
        check_val("ovw_a", bus.r_data[31:0], 32'h0000_0020);
`endif
        do_write(5, 0, 32'h8000_0000);
        do_read(5, "acc_row5_b");
`ifdef Q_TABLE_SAT_ACC_EN
        check_val("sat_mix", bus.r_data[31:0], 32'hFFFF_FFFF);
`else
        check_val("ovw_b", bus.r_data[31:0], 32'h8000_0000);
`endif

        for (int i = 0; i < 6; i++) begin
            do_write(10, int'($urandom_range(0, NA - 1)), $urandom);
            do_write(10, int'($urandom_range(0, NA - 1)), $urandom);
            do_read(10, "rnd_row10");
            start_scan(10);
            wait_valid("lat_rnd", NA - 1);
            tick;
        end

        tick; tick;
        check_val("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
